// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame sequencer.
//   SOF_DEFAULT  : default start-of-frame delimiter
//   state_e      : sequencer FSM states
//   ERR_*        : err_code values reported with frame_err
package uart_frame_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'h7E;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    DISPATCH,
    DONE
  } state_e;

  localparam logic [1:0] ERR_LEN_BAD = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;

endpackage

// File: rtl/uart_frame_sequencer_frame_buffer.sv
// Payload store for one frame: DEPTH x 8 register file.
//   clk_i   : clock
//   we_i    : write enable (synchronous write)
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (combinational read)
//   rdata_o : read data
// Contents are not reset; the sequencer only reads entries it has written.
module frame_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uart_frame_sequencer.sv
// Parses SOF/LEN/payload frames from the UART Rx byte strobe, buffers one
// frame and dispatches it to the LED shift register under valid/ready.
//   CLK, reset            : clock, synchronous active-high reset
//   rx_data, rx_valid     : received byte and its one-cycle strobe
//   sr_ready              : shift register accepts a byte
//   sr_data, sr_valid     : byte offered to the shift register
//   frame_done            : pulse after the last payload byte is accepted
//   frame_err, err_code   : error pulse and sticky cause
//   busy                  : sequencer not in IDLE
//   led_last              : last byte of the most recent completed frame
module uart_frame_sequencer
  import uart_frame_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT,
  parameter int unsigned MAX_LEN        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 34720
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       sr_ready,
  output logic [7:0] sr_data,
  output logic       sr_valid,
  output logic       frame_done,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [7:0] led_last
);

  localparam int unsigned IDXW = $clog2(MAX_LEN) + 1;
  localparam int unsigned AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [7:0]    MAX_LEN_B = MAX_LEN[7:0];
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [IDXW-1:0] wr_idx_q, wr_idx_d;
  logic [IDXW-1:0] rd_idx_q, rd_idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      sr_data_q, sr_data_d;
  logic [7:0]      led_last_q, led_last_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            err_pend_q, err_pend_d;

  logic            buf_we;
  logic [AW-1:0]   buf_raddr;
  logic [7:0]      buf_rdata;
  logic [IDXW-1:0] last_idx;
  logic            tmo;

  frame_buffer #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk_i   (CLK),
    .we_i    (buf_we),
    .waddr_i (wr_idx_q[AW-1:0]),
    .wdata_i (rx_data),
    .raddr_i (buf_raddr),
    .rdata_o (buf_rdata)
  );

  assign last_idx = IDXW'(len_q - 8'd1);
  assign tmo      = (cnt_q == TMO_LAST) && !rx_valid;

  // Outside DISPATCH the read port prefetches entry 0 for the first byte;
  // inside DISPATCH it looks one entry ahead of the byte being offered.
  assign buf_raddr = (state_q == DISPATCH) ? AW'(rd_idx_q + 1'b1) : '0;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    cnt_d      = '0;
    sr_data_d  = sr_data_q;
    led_last_d = led_last_q;
    err_code_d = err_code_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_pend_d = 1'b0;
    buf_we     = 1'b0;

    // An overrun deferred from the final-accept cycle fires here, one cycle
    // after frame_done, so the two pulses never coincide.
    if (err_pend_q) begin
      err_d      = 1'b1;
      err_code_d = ERR_OVERRUN;
    end

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (rx_valid && rx_data == SOF_BYTE) state_d = LEN;
      end

      LEN: begin
        if (rx_valid) begin
          if (rx_data == SOF_BYTE) begin
            state_d = LEN;
          end else if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN_BAD;
            state_d    = IDLE;
          end else begin
            len_d    = rx_data;
            wr_idx_d = '0;
            state_d  = PAYLOAD;
          end
        end else if (tmo) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = IDLE;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end

      PAYLOAD: begin
        if (rx_valid) begin
          buf_we = 1'b1;
          if (wr_idx_q == last_idx) begin
            rd_idx_d  = '0;
            // A one-byte frame is still being written, so bypass the store.
            sr_data_d = (wr_idx_q == '0) ? rx_data : buf_rdata;
            state_d   = DISPATCH;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end else if (tmo) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = IDLE;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end

      DISPATCH: begin
        if (sr_ready) begin
          if (rd_idx_q == last_idx) begin
            done_d     = 1'b1;
            led_last_d = sr_data_q;
            state_d    = DONE;
          end else begin
            rd_idx_d  = rd_idx_q + 1'b1;
            sr_data_d = buf_rdata;
          end
        end
        if (rx_valid) begin
          if (sr_ready && rd_idx_q == last_idx) begin
            err_pend_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_OVERRUN;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      cnt_q      <= '0;
      sr_data_q  <= '0;
      led_last_q <= '0;
      err_code_q <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      cnt_q      <= cnt_d;
      sr_data_q  <= sr_data_d;
      led_last_q <= led_last_d;
      err_code_q <= err_code_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
    end
  end

  assign sr_data    = sr_data_q;
  assign sr_valid   = (state_q == DISPATCH);
  assign frame_done = done_q;
  assign frame_err  = err_q;
  assign err_code   = err_code_q;
  assign busy       = (state_q != IDLE);
  assign led_last   = led_last_q;

endmodule

// File: tb/tb_uart_frame_sequencer.sv
module tb_uart_frame_sequencer;

  localparam int TMO  = 64;
  localparam int MAXL = 8;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       sr_ready;
  logic [7:0] sr_data;
  logic       sr_valid, frame_done, frame_err, busy;
  logic [1:0] err_code;
  logic [7:0] led_last;

  int total = 0;
  int bad   = 0;

  uart_frame_sequencer #(
    .SOF_BYTE       (8'h7E),
    .MAX_LEN        (MAXL),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .sr_ready   (sr_ready),
    .sr_data    (sr_data),
    .sr_valid   (sr_valid),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .busy       (busy),
    .led_last   (led_last)
  );

  always #5 CLK = ~CLK;

  // Ready generator: 0 always high, 1 random, 2 toggle every 3 cycles, 3 low.
  int rmode = 0;
  initial begin
    int t3;
    t3 = 0;
    sr_ready = 1'b0;
    forever begin
      @(posedge CLK); #1;
      case (rmode)
        0: sr_ready = 1'b1;
        1: sr_ready = 1'($urandom_range(0, 1));
        2: begin
          t3++;
          if (t3 == 3) begin t3 = 0; sr_ready = !sr_ready; end
        end
        default: sr_ready = 1'b0;
      endcase
    end
  end

  // Passive recorder: accepted bytes, pulses, hold-stability violations.
  logic [7:0] acc[$];
  int         acc_cyc[$];
  int         cyc = 0, n_done = 0, n_err = 0, n_both = 0, n_valid = 0, n_unstable = 0;
  logic [1:0] err_log = '0;
  logic       hold = 1'b0;
  logic [7:0] hold_data = '0;

  always @(negedge CLK) begin
    cyc <= cyc + 1;
    if (reset) begin
      hold <= 1'b0;
    end else begin
      if (sr_valid) n_valid <= n_valid + 1;
      if (hold && (!sr_valid || sr_data !== hold_data)) n_unstable <= n_unstable + 1;
      if (sr_valid && sr_ready) begin
        acc.push_back(sr_data);
        acc_cyc.push_back(cyc);
      end
      hold      <= sr_valid && !sr_ready;
      hold_data <= sr_data;
      if (frame_done) n_done <= n_done + 1;
      if (frame_err) begin n_err <= n_err + 1; err_log <= err_code; end
      if (frame_done && frame_err) n_both <= n_both + 1;
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic idle(input int n);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge CLK); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      if (!busy) begin ok = 1'b1; break; end
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(3);
    total++;
    if ({sr_data, sr_valid, frame_done, frame_err, err_code, busy, led_last} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got data=%h v=%b d=%b e=%b c=%b busy=%b led=%h, want all 0",
               sr_data, sr_valid, frame_done, frame_err, err_code, busy, led_last);
    end
    reset = 1'b0;
    idle(2);
    total++;
    if ({sr_valid, frame_done, frame_err, busy} !== 4'b0) begin
      bad++;
      $display("FAIL reset_release: got v=%b d=%b e=%b busy=%b, want 0", sr_valid, frame_done, frame_err, busy);
    end
  endtask

  task automatic test_stray_then_frame();
    int s, d0, e0;
    bit ok;
    logic [7:0] exp_b[3];
    exp_b = '{8'h55, 8'h57, 8'h41};
    rmode = 0; idle(2);
    s = acc.size(); d0 = n_done; e0 = n_err;
    send(8'hF4); send(8'h7E); send(8'h03); send(8'h55); send(8'h57); send(8'h41);
    @(negedge CLK);
    total++;
    if (sr_valid !== 1'b1 || sr_data !== 8'h55) begin
      bad++;
      $display("FAIL first_valid_latency: got v=%b data=%h, want v=1 data=55", sr_valid, sr_data);
    end
    wait_idle(ok);
    total++;
    if (!ok) begin bad++; $display("FAIL stray_idle_wait: busy stuck 1, want 0"); end
    total++;
    if (acc.size() - s !== 3) begin
      bad++; $display("FAIL stray_count: got %0d bytes, want 3", acc.size() - s);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (acc[s+i] !== exp_b[i]) begin
          bad++; $display("FAIL stray_byte%0d: got %h want %h", i, acc[s+i], exp_b[i]);
        end
      end
      total++;
      if (acc_cyc[s+1] != acc_cyc[s] + 1 || acc_cyc[s+2] != acc_cyc[s] + 2) begin
        bad++; $display("FAIL stray_rate: accept cycles %0d %0d %0d, want consecutive",
                        acc_cyc[s], acc_cyc[s+1], acc_cyc[s+2]);
      end
    end
    total++;
    if (n_done - d0 !== 1 || n_err - e0 !== 0) begin
      bad++; $display("FAIL stray_pulses: got done=%0d err=%0d, want 1 0", n_done - d0, n_err - e0);
    end
    total++;
    if (led_last !== 8'h41 || busy !== 1'b0) begin
      bad++; $display("FAIL stray_led: got led=%h busy=%b, want 41 0", led_last, busy);
    end
  endtask

  task automatic test_backpressure();
    int s, d0, u0;
    bit ok;
    logic [7:0] exp_b[4];
    exp_b = '{8'hC0, 8'hF0, 8'hFC, 8'hFF};
    rmode = 2; idle(1);
    s = acc.size(); d0 = n_done; u0 = n_unstable;
    send(8'h7E); send(8'h04); send(8'hC0); send(8'hF0); send(8'hFC); send(8'hFF);
    wait_idle(ok);
    total++;
    if (!ok || acc.size() - s !== 4) begin
      bad++; $display("FAIL bp_count: got %0d bytes ok=%b, want 4", acc.size() - s, ok);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (acc[s+i] !== exp_b[i]) begin
          bad++; $display("FAIL bp_byte%0d: got %h want %h", i, acc[s+i], exp_b[i]);
        end
      end
    end
    total++;
    if (n_unstable - u0 !== 0) begin
      bad++; $display("FAIL bp_stable: got %0d hold violations, want 0", n_unstable - u0);
    end
    total++;
    if (led_last !== 8'hFF || n_done - d0 !== 1) begin
      bad++; $display("FAIL bp_done: got led=%h done=%0d, want FF 1", led_last, n_done - d0);
    end
    rmode = 0;
  endtask

  task automatic test_bad_len();
    int e0, v0;
    logic [7:0] lens[2];
    lens = '{8'h00, 8'h09};
    rmode = 0;
    for (int k = 0; k < 2; k++) begin
      idle(2);
      e0 = n_err; v0 = n_valid;
      send(8'h7E); send(lens[k]);
      idle(3);
      total++;
      if (n_err - e0 !== 1 || err_log !== 2'b01 || err_code !== 2'b01) begin
        bad++; $display("FAIL badlen_%h: got errs=%0d code=%b, want 1 01", lens[k], n_err - e0, err_code);
      end
      total++;
      if (n_valid - v0 !== 0 || busy !== 1'b0) begin
        bad++; $display("FAIL badlen_%h_idle: got valid_cycles=%0d busy=%b, want 0 0", lens[k], n_valid - v0, busy);
      end
    end
  endtask

  task automatic test_timeout();
    int k, s;
    bit ok;
    rmode = 0; idle(2);
    send(8'h7E); send(8'h03); send(8'h55);
    k = -1;
    for (int i = 1; i <= 4 * TMO; i++) begin
      @(posedge CLK); #1;
      if (frame_err) begin k = i; break; end
    end
    total++;
    if (k != TMO || err_code !== 2'b10) begin
      bad++; $display("FAIL timeout_delay: got pulse after %0d clocks code=%b, want %0d 10", k, err_code, TMO);
    end
    idle(2);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL timeout_idle: got busy=%b want 0", busy); end
    s = acc.size();
    send(8'h7E); send(8'h01); send(8'hAA);
    wait_idle(ok);
    total++;
    if (!ok || acc.size() - s !== 1 || acc[acc.size()-1] !== 8'hAA || led_last !== 8'hAA) begin
      bad++; $display("FAIL timeout_next: got n=%0d led=%h, want 1 AA", acc.size() - s, led_last);
    end
  endtask

  task automatic test_overrun_resync();
    int s, d0, e0, b0;
    bit ok;
    rmode = 3; idle(2);
    s = acc.size(); d0 = n_done; e0 = n_err;
    send(8'h7E); send(8'h7E); send(8'h02); send(8'h11); send(8'h22);
    idle(2);
    send(8'h33);
    idle(2);
    total++;
    if (n_err - e0 !== 1 || err_log !== 2'b11 || sr_valid !== 1'b1 || sr_data !== 8'h11) begin
      bad++; $display("FAIL overrun_err: got errs=%0d code=%b v=%b data=%h, want 1 11 1 11",
                      n_err - e0, err_log, sr_valid, sr_data);
    end
    rmode = 0;
    wait_idle(ok);
    total++;
    if (!ok || acc.size() - s !== 2 || acc[s] !== 8'h11 || acc[s+1] !== 8'h22 || led_last !== 8'h22
        || n_done - d0 !== 1) begin
      bad++; $display("FAIL overrun_dispatch: got n=%0d led=%h done=%0d, want 2 22 1",
                      acc.size() - s, led_last, n_done - d0);
    end
    // Overrun landing on the final acceptance cycle.
    idle(2);
    d0 = n_done; e0 = n_err; b0 = n_both;
    send(8'h7E); send(8'h01); send(8'hAB); send(8'h33);
    wait_idle(ok);
    idle(3);
    total++;
    if (n_done - d0 !== 1 || n_err - e0 !== 1 || err_log !== 2'b11 || n_both - b0 !== 0) begin
      bad++; $display("FAIL overrun_last: got done=%0d err=%0d code=%b both=%0d, want 1 1 11 0",
                      n_done - d0, n_err - e0, err_log, n_both - b0);
    end
  endtask

  task automatic test_reset_mid_dispatch();
    int s, d0;
    bit ok;
    rmode = 3; idle(2);
    d0 = n_done;
    send(8'h7E); send(8'h02); send(8'h01); send(8'h02);
    idle(1);
    total++;
    if (sr_valid !== 1'b1) begin bad++; $display("FAIL rst_pre: got sr_valid=%b want 1", sr_valid); end
    reset = 1'b1;
    idle(1);
    total++;
    if ({sr_data, sr_valid, frame_done, frame_err, err_code, busy, led_last} !== '0) begin
      bad++; $display("FAIL rst_mid_outputs: got v=%b data=%h busy=%b led=%h, want all 0",
                      sr_valid, sr_data, busy, led_last);
    end
    reset = 1'b0;
    rmode = 0;
    idle(3);
    total++;
    if (n_done - d0 !== 0) begin bad++; $display("FAIL rst_no_done: got %0d want 0", n_done - d0); end
    s = acc.size();
    send(8'h7E); send(8'h01); send(8'h5A);
    wait_idle(ok);
    total++;
    if (!ok || acc.size() - s !== 1 || acc[s] !== 8'h5A || led_last !== 8'h5A || n_done - d0 !== 1) begin
      bad++; $display("FAIL rst_next_frame: got n=%0d led=%h done=%0d, want 1 5A 1",
                      acc.size() - s, led_last, n_done - d0);
    end
  endtask

  // Reference: a frame with 1..MAXL declared length yields its payload in
  // order and a done; any other length yields one LEN_BAD error.
  task automatic test_random();
    int s, d0, e0, u0, b0, len, n;
    bit ok;
    logic [7:0] pay[$];
    logic [7:0] b;
    logic [7:0] exp_led;
    exp_led = led_last;
    rmode = 1;
    for (int f = 0; f < 25; f++) begin
      idle($urandom_range(1, 4));
      s = acc.size(); d0 = n_done; e0 = n_err; u0 = n_unstable; b0 = n_both;
      n = $urandom_range(0, 3);
      for (int g = 0; g < n; g++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h7E) b = 8'h00;
        send(b);
      end
      send(8'h7E);
      if ($urandom_range(0, 3) == 0) send(8'h7E);
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 12) : $urandom_range(1, MAXL);
      send(8'(len));
      pay.delete();
      if (len >= 1 && len <= MAXL) begin
        for (int i = 0; i < len; i++) begin
          pay.push_back(8'($urandom_range(0, 255)));
          if (i > 0) idle($urandom_range(0, 5));
          send(pay[i]);
        end
        exp_led = pay[len-1];
      end
      wait_idle(ok);
      total++;
      if (!ok || acc.size() - s !== pay.size()) begin
        bad++; $display("FAIL rand%0d_count: got %0d bytes ok=%b, want %0d (len=%0d)",
                        f, acc.size() - s, ok, pay.size(), len);
      end else begin
        for (int i = 0; i < pay.size(); i++) begin
          total++;
          if (acc[s+i] !== pay[i]) begin
            bad++; $display("FAIL rand%0d_byte%0d: got %h want %h", f, i, acc[s+i], pay[i]);
          end
        end
      end
      total++;
      if (pay.size() > 0) begin
        if (n_done - d0 !== 1 || n_err - e0 !== 0 || led_last !== exp_led) begin
          bad++; $display("FAIL rand%0d_done: got done=%0d err=%0d led=%h, want 1 0 %h",
                          f, n_done - d0, n_err - e0, led_last, exp_led);
        end
      end else begin
        if (n_done - d0 !== 0 || n_err - e0 !== 1 || err_log !== 2'b01 || led_last !== exp_led) begin
          bad++; $display("FAIL rand%0d_badlen: got done=%0d err=%0d code=%b led=%h, want 0 1 01 %h",
                          f, n_done - d0, n_err - e0, err_log, led_last, exp_led);
        end
      end
      total++;
      if (n_unstable - u0 !== 0 || n_both - b0 !== 0) begin
        bad++; $display("FAIL rand%0d_protocol: got unstable=%0d both=%0d, want 0 0",
                        f, n_unstable - u0, n_both - b0);
      end
    end
    rmode = 0;
  endtask

  initial begin
    test_reset();
    test_stray_then_frame();
    test_backpressure();
    test_bad_len();
    test_timeout();
    test_overrun_resync();
    test_reset_mid_dispatch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_sequencer.md
Name: uart_frame_sequencer

Overview:
Parses framed command bytes from the UART receiver and feeds the payload to the LED shift-register datapath in order.
- Frame format: SOF (0x7E), LEN, then LEN payload bytes; no escaping.
- Sits between the UART Rx byte strobe and the shift-register load port inside ClockBaseTop.
- Buffers one frame, then dispatches it byte-by-byte under a valid/ready handshake and reports completion or errors.

Parameters:
- SOF_BYTE, 8'h7E, start-of-frame delimiter.
- MAX_LEN, 8, maximum payload bytes per frame (1..255).
- TIMEOUT_CYCLES, 34720, idle clocks allowed between bytes inside a frame (20 bit times at 1736 clk/bit).

Ports:
- CLK, in, 1, system clock; all logic on the rising edge.
- reset, in, 1, synchronous active-high reset.
- rx_data, in, 8, byte from the UART receiver.
- rx_valid, in, 1, one-cycle strobe qualifying rx_data.
- sr_ready, in, 1, shift register can accept a byte.
- sr_data, out, 8, byte presented to the shift register.
- sr_valid, out, 1, sr_data is valid.
- frame_done, out, 1, one-cycle pulse after the last payload byte is accepted.
- frame_err, out, 1, one-cycle error pulse.
- err_code, out, 2, error cause (01 LEN_BAD, 10 TIMEOUT, 11 OVERRUN); holds its last value.
- busy, out, 1, high in every state except IDLE.
- led_last, out, 8, last byte of the most recent completed frame.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0. Reset mid-frame or mid-dispatch aborts with no done/err pulse, and sr_valid drops on the next edge.
- IDLE: rx_valid with SOF_BYTE -> LEN. Any other byte is ignored silently.
- LEN:
  - rx_valid with SOF_BYTE -> stay in LEN (resync).
  - LEN = 0 or LEN > MAX_LEN -> frame_err, err_code=01, -> IDLE.
  - Otherwise latch len, wr_idx=0, -> PAYLOAD.
- PAYLOAD:
  - Each rx_valid writes buf[wr_idx] and increments wr_idx.
  - The write with wr_idx==len-1 -> DISPATCH, rd_idx=0.
  - SOF_BYTE inside the payload is ordinary data.
- Timeout (LEN and PAYLOAD only):
  - Idle counter clears on every rx_valid and on state entry, and increments otherwise.
  - At count==TIMEOUT_CYCLES-1 with no rx_valid: frame_err, err_code=10, -> IDLE, partial frame discarded.
- DISPATCH:
  - sr_valid=1 and sr_data=buf[rd_idx], registered.
  - First sr_valid appears on the cycle after the last payload rx_valid.
  - On sr_valid && sr_ready: rd_idx++. Sustained ready gives one byte per cycle.
  - sr_data must stay stable while sr_valid=1 and sr_ready=0.
  - Acceptance of index len-1 -> DONE; sr_valid drops on the next edge.
  - rx_valid during DISPATCH: byte dropped, frame_err with err_code=11; dispatch continues unaffected.
- DONE (one cycle): frame_done=1, led_last=buf[len-1], -> IDLE. rx_valid in DONE is handled exactly as in IDLE, so SOF -> LEN.
- frame_done and frame_err never pulse in the same cycle.
- Widths:
  - len is 8-bit.
  - wr_idx and rd_idx are $clog2(MAX_LEN)+1 bits and never wrap past len.
  - Timeout counter is $clog2(TIMEOUT_CYCLES) bits and saturates.

Decomposition:
- Package uart_frame_pkg holds:
  - SOF default.
  - State enum: IDLE, LEN, PAYLOAD, DISPATCH, DONE.
  - err_code localparams: ERR_LEN_BAD=2'b01, ERR_TIMEOUT=2'b10, ERR_OVERRUN=2'b11.
- One sub-module, frame_buffer: MAX_LEN x 8 register file with one synchronous write port and one read port. No reset on contents.
- The FSM, counters and outputs stay in uart_frame_sequencer.

Test Plan:
- Stray byte then frame: F4, 7E, 03, 55, 57, 41 with sr_ready=1 -> F4 ignored; sr_data 55, 57, 41 on consecutive accepts; frame_done once; led_last=41; busy back to 0.
- Backpressure: frame 7E 04 C0 F0 FC FF with sr_ready toggling every 3 cycles -> each byte held stable until accepted; order C0, F0, FC, FF; led_last=FF.
- Bad length: 7E 00 -> frame_err, err_code=01, no sr_valid. Same result for 7E 09 with MAX_LEN=8.
- Timeout: 7E 03 55, then silence -> frame_err, err_code=10 exactly TIMEOUT_CYCLES clocks after the 55 strobe; next frame 7E 01 AA dispatches AA.
- Overrun and resync:
  - 7E 7E 02 11 22, with 33 sent during dispatch and sr_ready held low.
  - Required: resync on the double SOF; frame_err with err_code=11; 11 and 22 still dispatched; led_last=22.
- Reset mid-dispatch: assert reset while sr_valid=1 -> all outputs 0 next cycle, no frame_done; the following frame processes normally.
